// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register of the MIPS datapath.
// Registers the ALU result and control bundle for the memory stage, checks
// load/store alignment, builds lane-replicated store data and byte enables,
// and (optionally) resolves conditional branches and raises the upstream flush.
// Optional feature macro: EXMEM_BRANCH_EN enables branch resolution,
// BranchTaken/BranchTarget/FlushOut and the self-squash of the instruction
// following a taken branch. Without it those outputs are tied to 0.
module ex_mem_stage (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        EX_Valid,
  input  logic [31:0] EX_ALUResult,
  input  logic        EX_Zero,
  input  logic [31:0] EX_WriteData,
  input  logic [4:0]  EX_WriteReg,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic        EX_MemWrite,
  input  logic        EX_MemToReg,
  input  logic [1:0]  EX_MemSize,
  input  logic [1:0]  EX_BranchType,
  input  logic [31:0] EX_BranchTarget,
  output logic        MEM_Valid,
  output logic [31:0] MEM_ALUResult,
  output logic [31:0] MEM_StoreData,
  output logic [3:0]  MEM_ByteEn,
  output logic [4:0]  MEM_WriteReg,
  output logic        MEM_RegWrite,
  output logic        MEM_MemRead,
  output logic        MEM_MemWrite,
  output logic        MEM_MemToReg,
  output logic [1:0]  MEM_MemSize,
  output logic        BranchTaken,
  output logic [31:0] BranchTarget,
  output logic        FlushOut,
  output logic        MEM_Misaligned,
  output logic        AlignErr
);

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;
  localparam logic [1:0] BR_CMP  = 2'b11;

  // Store data replicated into every lane the access may hit; size 11 is a word.
  function automatic logic [31:0] lane_data(input logic [1:0] size,
                                            input logic [31:0] d);
    logic [31:0] r;
    case (size)
      SZ_HALF: r = {d[15:0], d[15:0]};
      SZ_BYTE: r = {4{d[7:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Byte enables selected by access size and the low address bits.
  function automatic logic [3:0] lane_en(input logic [1:0] size,
                                         input logic [1:0] addr);
    logic [3:0] r;
    case (size)
      SZ_HALF: r = addr[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: r = 4'b0001 << addr;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Word needs addr 00, half needs an even address, byte is always aligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr);
    logic r;
    case (size)
      SZ_HALF: r = addr[0];
      SZ_BYTE: r = 1'b0;
      default: r = (addr != 2'b00);
    endcase
    return r;
  endfunction

  logic        valid_q,      valid_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] store_data_q, store_data_d;
  logic [3:0]  byte_en_q,    byte_en_d;
  logic [4:0]  write_reg_q,  write_reg_d;
  logic        reg_write_q,  reg_write_d;
  logic        mem_read_q,   mem_read_d;
  logic        mem_write_q,  mem_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic [1:0]  mem_size_q,   mem_size_d;
  logic        misaligned_q, misaligned_d;
  logic        align_err_q,  align_err_d;

  logic        ex_mem_access;
  logic        ex_misaligned;
  logic        ex_taken;
  logic        squash;

`ifdef EXMEM_BRANCH_EN
  logic        branch_taken_q,  branch_taken_d;
  logic [31:0] branch_target_q, branch_target_d;

  // Branch condition from the ALU outputs; the compare types have already
  // folded their sign/zero test into bit 0 of the ALU result.
  always_comb begin
    ex_taken = 1'b0;
    case (EX_BranchType)
      BR_EQ:   ex_taken = EX_Zero;
      BR_NE:   ex_taken = ~EX_Zero;
      BR_CMP:  ex_taken = EX_ALUResult[0];
      default: ex_taken = 1'b0;
    endcase
    ex_taken = ex_taken & EX_Valid;
  end

  // A taken branch in MEM means the instruction now in EX is on the wrong
  // path, so it is discarded regardless of Stall.
  assign squash = Flush | branch_taken_q;
`else
  logic unused_branch_inputs;
  assign unused_branch_inputs = ^{EX_BranchType, EX_BranchTarget, EX_Zero,
                                  BR_EQ, BR_NE, BR_CMP};
  assign ex_taken = 1'b0;
  assign squash   = Flush;
`endif

  // Next-state: squash loads a bubble, stall holds, otherwise capture EX.
  always_comb begin
    ex_mem_access = EX_Valid & (EX_MemRead | EX_MemWrite);
    ex_misaligned = ex_mem_access & is_misaligned(EX_MemSize, EX_ALUResult[1:0]);

    valid_d      = valid_q;
    alu_result_d = alu_result_q;
    store_data_d = store_data_q;
    byte_en_d    = byte_en_q;
    write_reg_d  = write_reg_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    mem_size_d   = mem_size_q;
    misaligned_d = misaligned_q;
    align_err_d  = align_err_q;
`ifdef EXMEM_BRANCH_EN
    branch_taken_d  = branch_taken_q;
    branch_target_d = branch_target_q;
`endif

    if (squash) begin
      valid_d      = 1'b0;
      alu_result_d = '0;
      store_data_d = '0;
      byte_en_d    = '0;
      write_reg_d  = '0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      mem_size_d   = '0;
      misaligned_d = 1'b0;
`ifdef EXMEM_BRANCH_EN
      branch_taken_d  = 1'b0;
      branch_target_d = '0;
`endif
    end else if (!Stall) begin
      valid_d      = EX_Valid;
      alu_result_d = EX_ALUResult;
      store_data_d = lane_data(EX_MemSize, EX_WriteData);
      byte_en_d    = (ex_mem_access && !ex_misaligned) ?
                     lane_en(EX_MemSize, EX_ALUResult[1:0]) : 4'b0000;
      write_reg_d  = EX_WriteReg;
      reg_write_d  = EX_Valid & EX_RegWrite & ~ex_misaligned;
      mem_read_d   = EX_Valid & EX_MemRead  & ~ex_misaligned;
      mem_write_d  = EX_Valid & EX_MemWrite & ~ex_misaligned;
      mem_to_reg_d = EX_Valid & EX_MemToReg;
      mem_size_d   = EX_MemSize;
      misaligned_d = ex_misaligned;
      align_err_d  = align_err_q | ex_misaligned;
`ifdef EXMEM_BRANCH_EN
      branch_taken_d  = ex_taken;
      branch_target_d = EX_BranchTarget;
`endif
    end
  end

  // Stage registers with synchronous reset to all-zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q      <= 1'b0;
      alu_result_q <= '0;
      store_data_q <= '0;
      byte_en_q    <= '0;
      write_reg_q  <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_size_q   <= '0;
      misaligned_q <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      byte_en_q    <= byte_en_d;
      write_reg_q  <= write_reg_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_size_q   <= mem_size_d;
      misaligned_q <= misaligned_d;
      align_err_q  <= align_err_d;
    end
  end

`ifdef EXMEM_BRANCH_EN
  // Branch decision registers, cleared by reset like the rest of the stage.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
    end else begin
      branch_taken_q  <= branch_taken_d;
      branch_target_q <= branch_target_d;
    end
  end

  assign BranchTaken  = branch_taken_q;
  assign BranchTarget = branch_target_q;
  assign FlushOut     = branch_taken_q;
`else
  assign BranchTaken  = 1'b0;
  assign BranchTarget = '0;
  assign FlushOut     = 1'b0;
`endif

  assign MEM_Valid      = valid_q;
  assign MEM_ALUResult  = alu_result_q;
  assign MEM_StoreData  = store_data_q;
  assign MEM_ByteEn     = byte_en_q;
  assign MEM_WriteReg   = write_reg_q;
  assign MEM_RegWrite   = reg_write_q;
  assign MEM_MemRead    = mem_read_q;
  assign MEM_MemWrite   = mem_write_q;
  assign MEM_MemToReg   = mem_to_reg_q;
  assign MEM_MemSize    = mem_size_q;
  assign MEM_Misaligned = misaligned_q;
  assign AlignErr       = align_err_q;

endmodule
